// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: operand width default and the
// Controller op codes, formed as {Shift1,Shift0}.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [5:0] {
    OP_HOLD  = 6'b000_000,
    OP_LOAD  = 6'b101_101,
    OP_ADD   = 6'b010_010,
    OP_SHIFT = 6'b111_000
  } op_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: M, {C,A,Q} and shift count, stepped by Controller op codes.
// One edge per op; there is no backpressure, and Valid freezes ADD/SHIFT until LOAD or Clear.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Clear,
  input  logic [2:0]         Shift1,
  input  logic [2:0]         Shift0,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Valid,
  output logic               Illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       op;

  assign op = {Shift1, Shift0};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_q       <= '0;
      a_q       <= '0;
      c_q       <= 1'b0;
      q_q       <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      a_q       <= a_d;
      c_q       <= c_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    m_d       = m_q;
    a_d       = a_q;
    c_d       = c_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (!Clear) begin
      m_d       = '0;
      a_d       = '0;
      c_d       = 1'b0;
      q_d       = '0;
      cnt_d     = '0;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (op)
        OP_HOLD: ;
        OP_LOAD: begin
          m_d     = Multiplicand;
          q_d     = Multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
        OP_ADD: begin
          if (!valid_q) begin
            if (q_q[0]) {c_d, a_d} = {1'b0, a_q} + {1'b0, m_q};
            else        c_d = 1'b0;
          end
        end
        OP_SHIFT: begin
          if (!valid_q) begin
            {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            // Valid rises on the same edge that completes the last shift.
            if (cnt_q + CW'(1) == CW'(WIDTH)) valid_d = 1'b1;
          end
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  assign Product = {a_q, q_q};
  assign Valid   = valid_q;
  assign Illegal = illegal_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Randomised and directed bench for mult_datapath against an arithmetic model.
module tb_mult_datapath;

  localparam int W = 4;
  localparam logic [5:0] C_HOLD  = 6'b000_000;
  localparam logic [5:0] C_LOAD  = 6'b101_101;
  localparam logic [5:0] C_ADD   = 6'b010_010;
  localparam logic [5:0] C_SHIFT = 6'b111_000;
  localparam logic [5:0] C_BAD   = 6'b011_000;

  logic           Clock;
  logic           Reset;
  logic           Clear;
  logic [2:0]     Shift1, Shift0;
  logic [W-1:0]   Multiplicand, Multiplier;
  logic [2*W-1:0] Product;
  logic           Valid, Illegal;

  int checks = 0;
  int errors = 0;

  // Model: p holds {C,A,Q} as one integer; M kept separately.
  int m_mul, p, cnt;
  bit m_valid, m_illegal;

  mult_datapath #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Clear(Clear),
    .Shift1(Shift1), .Shift0(Shift0),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Product(Product), .Valid(Valid), .Illegal(Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge Clock or negedge Reset) begin
    if (!Reset || !Clear) begin
      m_mul = 0; p = 0; cnt = 0; m_valid = 0; m_illegal = 0;
    end else begin
      case ({Shift1, Shift0})
        C_HOLD: ;
        C_LOAD: begin
          m_mul = int'(Multiplicand); p = int'(Multiplier); cnt = 0; m_valid = 0;
        end
        C_ADD: if (!m_valid) begin
          if (p % 2 == 1)
            p = (p % (1 << W)) + ((((p >> W) % (1 << W)) + m_mul) << W);
          else
            p = p % (1 << (2 * W));
        end
        C_SHIFT: if (!m_valid) begin
          p = p / 2;
          cnt++;
          if (cnt == W) m_valid = 1;
        end
        default: m_illegal = 1;
      endcase
    end
  end

  always @(negedge Clock) begin
    check("valid", int'(Valid), int'(m_valid));
    check("illegal", int'(Illegal), int'(m_illegal));
    check("product", int'(Product), p % (1 << (2 * W)));
  end

  task automatic step(input logic [5:0] op, input logic clr,
                      input logic [W-1:0] mc, input logic [W-1:0] mp);
    Clear = clr;
    {Shift1, Shift0} = op;
    Multiplicand = mc;
    Multiplier = mp;
    @(posedge Clock);
    #1;
  endtask

  // Controller-style run; operands present only at the LOAD edge, garbage afterwards.
  task automatic run(input logic [W-1:0] mc, input logic [W-1:0] mp,
                     input bit do_clear, input bit holds);
    if (do_clear) step(C_HOLD, 1'b0, W'($urandom), W'($urandom));
    step(C_LOAD, 1'b1, mc, mp);
    for (int i = 0; i < W; i++) begin
      if (holds && $urandom_range(0, 2) == 0) step(C_HOLD, 1'b1, W'($urandom), W'($urandom));
      step(C_ADD, 1'b1, W'($urandom), W'($urandom));
      if (i == W - 1) check("valid_before_last", int'(Valid), 0);
      step(C_SHIFT, 1'b1, W'($urandom), W'($urandom));
    end
  endtask

  initial begin
    Reset = 1'b0; Clear = 1'b1; Shift1 = 3'b0; Shift0 = 3'b0;
    Multiplicand = '0; Multiplier = '0;
    #2;
    check("reset_product", int'(Product), 0);
    check("reset_valid", int'(Valid), 0);
    check("reset_illegal", int'(Illegal), 0);
    repeat (2) @(posedge Clock);
    #3 Reset = 1'b1;

    run(4'd13, 4'd11, 1'b1, 1'b0);
    check("13x11_valid", int'(Valid), 1);
    check("13x11_product", int'(Product), 'h8F);
    step(C_ADD, 1'b1, 4'd7, 4'd7);
    step(C_SHIFT, 1'b1, 4'd7, 4'd7);
    step(C_ADD, 1'b1, 4'd7, 4'd7);
    check("frozen_product", int'(Product), 'h8F);
    check("frozen_valid", int'(Valid), 1);

    run(4'd15, 4'd15, 1'b1, 1'b0);
    check("15x15_product", int'(Product), 'hE1);
    check("15x15_valid", int'(Valid), 1);
    run(4'd0, 4'd9, 1'b1, 1'b0);
    check("0x9_product", int'(Product), 0);
    check("0x9_valid", int'(Valid), 1);
    run(4'd9, 4'd0, 1'b0, 1'b0);
    check("9x0_product", int'(Product), 0);
    check("9x0_valid", int'(Valid), 1);

    // Illegal code mid-run, then Clear.
    step(C_HOLD, 1'b0, 4'd0, 4'd0);
    step(C_LOAD, 1'b1, 4'd5, 4'd3);
    step(C_ADD, 1'b1, 4'd0, 4'd0);
    check("pre_bad_product", int'(Product), 'h53);
    step(C_BAD, 1'b1, 4'd0, 4'd0);
    check("bad_illegal", int'(Illegal), 1);
    check("bad_hold_product", int'(Product), 'h53);
    step(C_SHIFT, 1'b1, 4'd0, 4'd0);
    check("illegal_sticky", int'(Illegal), 1);
    step(C_HOLD, 1'b0, 4'd0, 4'd0);
    check("clear_illegal", int'(Illegal), 0);
    check("clear_product", int'(Product), 0);

    // Asynchronous reset between ADD and SHIFT, with Illegal already set.
    step(C_LOAD, 1'b1, 4'd5, 4'd3);
    step(C_BAD, 1'b1, 4'd0, 4'd0);
    step(C_ADD, 1'b1, 4'd0, 4'd0);
    {Shift1, Shift0} = C_SHIFT;
    #2 Reset = 1'b0;
    #1;
    check("midreset_product", int'(Product), 0);
    check("midreset_valid", int'(Valid), 0);
    check("midreset_illegal", int'(Illegal), 0);
    #2 Reset = 1'b1;
    run(4'd6, 4'd7, 1'b1, 1'b0);
    check("6x7_product", int'(Product), 'h2A);
    check("6x7_valid", int'(Valid), 1);

    run(4'd3, 4'd5, 1'b0, 1'b1);
    check("sampled_operand_product", int'(Product), 'h0F);

    // Randomised Controller-style runs checked against plain multiplication.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      run(a, b, bit'($urandom_range(0, 1)), 1'b1);
      check("rand_product", int'(Product), int'(a) * int'(b));
      check("rand_valid", int'(Valid), 1);
    end

    // Unconstrained op mix, checked only by the per-cycle model compare.
    for (int k = 0; k < 800; k++) begin
      int r;
      logic [5:0] op;
      logic clr;
      r = $urandom_range(0, 99);
      clr = 1'b1;
      if (r < 3) begin
        clr = 1'b0; op = 6'($urandom);
      end else if (r < 6) begin
        op = 6'($urandom);
        if (op == C_HOLD || op == C_LOAD || op == C_ADD || op == C_SHIFT) op = C_BAD;
      end else if (r < 16) op = C_LOAD;
      else if (r < 50) op = C_ADD;
      else if (r < 85) op = C_SHIFT;
      else op = C_HOLD;
      step(op, clr, W'($urandom), W'($urandom));
    end

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
